// File: rtl/alu_pkg.sv
// Opcode constants, request layout and opcode legality shared by the issue queue and the ALU.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] OP_AND = 4'b0100;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
   localparam logic [OP_W-1:0] OP_NOR = 4'b0111;
   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLT = 4'b1010;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
   } alu_req_t;

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Request, issue and result signals of the ALU issue queue, plus a queue-occupancy debug view.
interface alu_issue_queue_if
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3,
   parameter int CNT_W = 8
);
   // Request handshake: a transfer happens on a rising edge where in_valid
   // and in_ready are both 1; the requester keeps in_a/in_b/in_op stable
   // until then, and in_ready never depends on in_valid.
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_W-1:0]       in_a;
   logic [DATA_W-1:0]       in_b;
   logic [OP_W-1:0]         in_op;
   logic                    alu_stall;
   logic [DATA_W-1:0]       A;
   logic [DATA_W-1:0]       B;
   logic [OP_W-1:0]         Opin;
   logic                    issue_vld;
   logic [TAG_W-1:0]        issue_tag;
   logic                    res_vld;
   logic [TAG_W-1:0]        res_tag;
   logic                    ill_op;
   logic [CNT_W-1:0]        ill_cnt;
   logic [$clog2(DEPTH):0]  q_count;

   modport master (
      output in_valid, in_a, in_b, in_op, alu_stall,
      input  in_ready, A, B, Opin, issue_vld, issue_tag,
             res_vld, res_tag, ill_op, ill_cnt, q_count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, alu_stall,
      output in_ready, A, B, Opin, issue_vld, issue_tag,
             res_vld, res_tag, ill_op, ill_cnt, q_count
   );

endinterface

// File: rtl/alu_req_fifo.sv
// Power-of-two request FIFO; push is ignored when full, pop is ignored when empty.
module alu_req_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 68,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage in front of the ALU: filters illegal opcodes, queues requests,
// issues one per clock and carries a tag alongside the ALU latency.
module alu_issue_queue
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 2,
   parameter int TAG_W   = 3,
   parameter int CNT_W   = 8
) (
   input logic              clk,
   input logic              reset,
   alu_issue_queue_if.slave bus
);

   localparam logic [TAG_W-1:0] TAG_ONE = 1;
   localparam logic [CNT_W-1:0] ILL_ONE = 1;

   alu_req_t               req_in;
   alu_req_t               head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   accept;
   logic                   legal;
   logic                   push;
   logic                   pop;

   logic [DATA_W-1:0]      a_q;
   logic [DATA_W-1:0]      b_q;
   logic [OP_W-1:0]        op_q;
   logic                   issue_vld_q;
   logic [TAG_W-1:0]       issue_tag_q;
   logic [TAG_W-1:0]       tag_cnt;
   logic                   ill_op_q;
   logic [CNT_W-1:0]       ill_cnt_q;
   logic [TAG_W:0]         tag_pipe [ALU_LAT];

   assign req_in = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
   assign legal  = op_legal(bus.in_op);
   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && legal;
   assign pop    = !fifo_empty && !bus.alu_stall;

   alu_req_fifo #(.DEPTH(DEPTH), .WIDTH($bits(alu_req_t))) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (req_in),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
   assign bus.in_ready  = !reset && !fifo_full;
   assign bus.q_count   = fifo_count;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.Opin      = op_q;
   assign bus.issue_vld = issue_vld_q;
   assign bus.issue_tag = issue_tag_q;
   assign bus.res_vld   = tag_pipe[ALU_LAT-1][TAG_W];
   assign bus.res_tag   = tag_pipe[ALU_LAT-1][TAG_W-1:0];
   assign bus.ill_op    = ill_op_q;
   assign bus.ill_cnt   = ill_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         issue_vld_q <= 1'b0;
         issue_tag_q <= '0;
         tag_cnt     <= '0;
      end else if (pop) begin
         a_q         <= head.a;
         b_q         <= head.b;
         op_q        <= head.op;
         issue_vld_q <= 1'b1;
         issue_tag_q <= tag_cnt;
         tag_cnt     <= tag_cnt + TAG_ONE;
      end else begin
         issue_vld_q <= 1'b0;
      end
   end

   // Last stage lines up with the ALU result register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ALU_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= {issue_vld_q, issue_tag_q};
         for (int i = 1; i < ALU_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ill_op_q  <= 1'b0;
         ill_cnt_q <= '0;
      end else begin
         ill_op_q <= accept && !legal;
         if (accept && !legal && ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + ILL_ONE;
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed and random stimulus for alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;
   import alu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int ALU_LAT = 2;
   localparam int TAG_W   = 3;
   localparam int CNT_W   = 8;
   localparam int NTAGS   = 1 << TAG_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alu_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

   alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit rand_stall = 0;

   logic [67:0]      exp_q [$];
   int               res_due [$];
   logic [TAG_W-1:0] res_tq [$];
   int               issued_total = 0;
   int               ill_model = 0;
   bit               ill_pend = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit legal_ref(input logic [3:0] op);
      logic [3:0] ops [7] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0000, 4'b0010, 4'b1010};
      foreach (ops[i]) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: accepted legal requests leave in order, tags count issues
   // modulo 2^TAG_W, and every issue produces one result ALU_LAT clocks later.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         res_due.delete();
         res_tq.delete();
         issued_total = 0;
         ill_model    = 0;
         ill_pend     = 0;
      end else begin
         bit exp_res;
         if (bus.issue_vld) begin
            if (exp_q.size() == 0) begin
               chk("issue_unexpected", bus.issue_vld, 0);
            end else begin
               logic [67:0] item;
               item = exp_q.pop_front();
               chk("issue_data", {bus.A, bus.B, bus.Opin}, item);
               chk("issue_tag", bus.issue_tag, issued_total % NTAGS);
               res_due.push_back(cyc + ALU_LAT);
               res_tq.push_back(TAG_W'(issued_total % NTAGS));
               issued_total++;
            end
         end
         exp_res = (res_due.size() > 0) && (res_due[0] == cyc);
         chk("res_vld", bus.res_vld, exp_res);
         if (exp_res) begin
            chk("res_tag", bus.res_tag, res_tq[0]);
            void'(res_due.pop_front());
            void'(res_tq.pop_front());
         end
         if (ill_pend && ill_model < CNT_MAX) ill_model++;
         chk("ill_op", bus.ill_op, ill_pend);
         chk("ill_cnt", bus.ill_cnt, ill_model);
         chk("in_ready", bus.in_ready, exp_q.size() != DEPTH);
         chk("q_count", bus.q_count, exp_q.size());
         ill_pend = 0;
         if (bus.in_valid && bus.in_ready) begin
            if (legal_ref(bus.in_op)) exp_q.push_back({bus.in_a, bus.in_b, bus.in_op});
            else ill_pend = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_stall) bus.alu_stall = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      int n = 0;
      bit acc;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, {bus.A, bus.B, bus.Opin}, 0);
      chk({tag, "_ctl"}, {bus.issue_vld, bus.issue_tag, bus.res_vld, bus.res_tag,
                          bus.ill_op, bus.ill_cnt, bus.in_ready, bus.q_count}, 0);
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_release", bus.in_ready, 1);
      step();
   endtask

   function automatic logic [3:0] rand_legal();
      logic [3:0] ops [7] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0000, 4'b0010, 4'b1010};
      return ops[$urandom_range(0, 6)];
   endfunction

   initial begin
      int base;
      int waited;
      logic [3:0] op;
      logic [31:0] ha, hb;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = '0;
      bus.alu_stall = 1'b0;

      // Power-on reset
      #1;
      chk_all_zero("por");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("por_release_ready", bus.in_ready, 1);
      step();

      // 1: single ADD, two-clock issue latency, result ALU_LAT later
      send(32'd5, 32'd3, 4'b0000);
      @(negedge clk);
      chk("t1_no_bypass", bus.issue_vld, 0);
      @(negedge clk);
      chk("t1_issue_vld", bus.issue_vld, 1);
      chk("t1_issue", {bus.A, bus.B, bus.Opin}, {32'd5, 32'd3, 4'b0000});
      chk("t1_tag", bus.issue_tag, 0);
      repeat (ALU_LAT - 1) begin
         @(negedge clk);
         chk("t1_res_early", bus.res_vld, 0);
      end
      @(negedge clk);
      chk("t1_res", {bus.res_vld, bus.res_tag}, {1'b1, 3'd0});
      step();

      // 2: fill under stall, fifth request held, release drains in order
      do_reset();
      bus.alu_stall = 1'b1;
      for (int i = 0; i < 4; i++) send($urandom(), $urandom(), rand_legal());
      @(negedge clk);
      chk("t2_full_ready", bus.in_ready, 0);
      step();
      ha = $urandom();
      hb = $urandom();
      bus.in_valid = 1'b1;
      bus.in_a = ha;
      bus.in_b = hb;
      bus.in_op = 4'b0010;
      repeat (3) begin
         @(negedge clk);
         chk("t2_held", bus.in_ready, 0);
         step();
      end
      base = issued_total;
      bus.alu_stall = 1'b0;
      send(ha, hb, 4'b0010);
      idle(8);
      chk("t2_issued", issued_total - base, 5);

      // 3: illegal opcodes are dropped and counted, counter saturates
      do_reset();
      send($urandom(), $urandom(), 4'b1111);
      send($urandom(), $urandom(), 4'b0001);
      idle(3);
      chk("t3_ill_cnt2", bus.ill_cnt, 2);
      chk("t3_none_issued", issued_total, 0);
      for (int i = 0; i < 300; i++) begin
         do op = 4'($urandom_range(0, 15)); while (legal_ref(op));
         send($urandom(), $urandom(), op);
      end
      idle(3);
      chk("t3_ill_sat", bus.ill_cnt, CNT_MAX);

      // 4: full queue drained while refilling; tag and pointers wrap
      do_reset();
      bus.alu_stall = 1'b1;
      for (int i = 0; i < 4; i++) send($urandom(), $urandom(), rand_legal());
      bus.alu_stall = 1'b0;
      for (int i = 0; i < 12; i++) send($urandom(), $urandom(), rand_legal());
      idle(10);
      chk("t4_issued", issued_total, 16);

      // 5: reset with three queued and one in flight
      do_reset();
      bus.alu_stall = 1'b1;
      for (int i = 0; i < 4; i++) send($urandom(), $urandom(), rand_legal());
      bus.alu_stall = 1'b0;
      @(posedge clk);
      #1;
      bus.alu_stall = 1'b1;
      @(negedge clk);
      chk("t5_inflight", {bus.issue_vld, bus.q_count}, {1'b1, 3'd3});
      #1;
      reset = 1'b1;
      #1;
      chk_all_zero("t5_reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bus.alu_stall = 1'b0;
      @(negedge clk);
      chk("t5_ready_release", bus.in_ready, 1);
      repeat (6) begin
         @(negedge clk);
         chk("t5_no_res", {bus.res_vld, bus.issue_vld}, 0);
      end
      step();

      // 6: random legal traffic with a toggling stall
      rand_stall = 1;
      for (int i = 0; i < 200; i++) begin
         send($urandom(), $urandom(), rand_legal());
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rand_stall = 0;
      bus.alu_stall = 1'b0;
      waited = 0;
      while ((exp_q.size() != 0 || res_due.size() != 0) && waited < 500) begin
         step();
         waited++;
      end
      chk("t6_drained", exp_q.size() + res_due.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
